// File: rtl/turbo_encoder_if.sv
// Message-in / codeword-out handshake bundle for turbo_encoder.
`timescale 1ns/1ps
interface turbo_encoder_if;
  logic [15:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [53:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, busy_o
  );

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, busy_o
  );
endinterface

// File: rtl/turbo_encoder.sv
// Rate-1/3 turbo encoder: two memory-3 RSC encoders (fb 13, ff 15 octal), K=16,
// encoder 1 tail-terminated, encoder 2 fed through pi(i) = (A*i + B) mod 16.
`timescale 1ns/1ps
module turbo_encoder #(
  parameter int unsigned ILV_A = 5,
  parameter int unsigned ILV_B = 3
) (
  input logic            clk_p_i,
  input logic            reset_n_i,
  turbo_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENC, TAIL, OUT} state_e;

  localparam logic [3:0] ILV_A4 = ILV_A[3:0];
  localparam logic [3:0] ILV_B4 = ILV_B[3:0];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] msg_q, msg_d;
  logic [15:0] z1_q, z1_d;
  logic [15:0] z2_q, z2_d;
  logic [2:0]  enc1_q, enc1_d;
  logic [2:0]  enc2_q, enc2_d;
  logic [2:0]  xt_q, xt_d;
  logic [2:0]  zt_q, zt_d;
  logic [53:0] data_q, data_d;

  logic [3:0]  pi_idx;
  logic        b1, b2, a1, a2, p1, p2;

  // Encoder state packing: [2]=s1, [1]=s2, [0]=s3.
  always_comb begin
    pi_idx = ILV_A4 * cnt_q + ILV_B4;
    b1     = msg_q[cnt_q];
    b2     = msg_q[pi_idx];
    a1     = b1 ^ enc1_q[1] ^ enc1_q[0];
    a2     = b2 ^ enc2_q[1] ^ enc2_q[0];
    p1     = a1 ^ enc1_q[2] ^ enc1_q[0];
    p2     = a2 ^ enc2_q[2] ^ enc2_q[0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    z1_d    = z1_q;
    z2_d    = z2_q;
    enc1_d  = enc1_q;
    enc2_d  = enc2_q;
    xt_d    = xt_q;
    zt_d    = zt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          msg_d   = bus.data_i;
          enc1_d  = '0;
          enc2_d  = '0;
          cnt_d   = '0;
          state_d = ENC;
        end
      end
      ENC: begin
        // Parity shifts in at the MSB so bit i lands at index i after 16 steps.
        enc1_d = {a1, enc1_q[2:1]};
        enc2_d = {a2, enc2_q[2:1]};
        z1_d   = {p1, z1_q[15:1]};
        z2_d   = {p2, z2_q[15:1]};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          cnt_d   = '0;
          state_d = TAIL;
        end
      end
      TAIL: begin
        // Tail input cancels the feedback, so a=0 and the register drains.
        xt_d   = {enc1_q[1] ^ enc1_q[0], xt_q[2:1]};
        zt_d   = {enc1_q[2] ^ enc1_q[0], zt_q[2:1]};
        enc1_d = {1'b0, enc1_q[2:1]};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd2) begin
          data_d  = {zt_d, xt_d, z2_q, z1_q, msg_q};
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      msg_q   <= '0;
      z1_q    <= '0;
      z2_q    <= '0;
      enc1_q  <= '0;
      enc2_q  <= '0;
      xt_q    <= '0;
      zt_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
      enc1_q  <= enc1_d;
      enc2_q  <= enc2_d;
      xt_q    <= xt_d;
      zt_q    <= zt_d;
      data_q  <= data_d;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == OUT);
  assign bus.busy_o  = (state_q == ENC) || (state_q == TAIL);
  assign bus.data_o  = data_q;

endmodule

// File: doc/turbo_encoder.md
Name: turbo_encoder

Overview:
- Rate-1/3 parallel-concatenated convolutional (turbo) encoder that generates the 54-bit codeword consumed by the turbo decoder stage.
- Takes a 16-bit message and runs two identical memory-3 RSC encoders one bit per cycle. Encoder 2 sees an interleaved copy of the message.
- Terminates encoder 1 with 3 tail steps. Encoder 2 is left unterminated.
- Presents the packed codeword on a valid/ready output interface.

Parameters:
- ILV_A, 5, interleaver multiplier. Must be odd.
- ILV_B, 3, interleaver offset, 0..15.
- Interleaver: pi(i) = (ILV_A*i + ILV_B) mod 16. Message length K is fixed at 16.

Ports:
- clk_p_i  in  1  clock, rising edge
- reset_n_i  in  1  reset, asynchronous, active-low
- data_i  in  16  message u[15:0]; u[0] is encoded first
- valid_i  in  1  data_i valid
- ready_o  out  1  encoder can accept a message
- data_o  out  54  codeword
- valid_o  out  1  data_o valid
- ready_i  in  1  downstream accepts data_o
- busy_o  out  1  high in ENC or TAIL

Behaviour:
- Reset: reset is reset_n_i, asynchronous, active-low; clock is clk_p_i. On reset:
  - state=IDLE, ready_o=1, valid_o=0, busy_o=0, data_o=0, both encoder states=000, bit counter=0.
- Reset mid-operation aborts the message with no output; the message is lost.
- FSM states IDLE, ENC, TAIL, OUT:
  - IDLE: ready_o=1. On an edge with valid_i=1, capture data_i, clear both encoder states and the counter, go to ENC.
  - ENC: 16 edges, bit index i=0..15 (counter). After i=15, go to TAIL with counter=0.
  - TAIL: 3 edges, t=0..2. After t=2, go to OUT and assert valid_o.
  - OUT: data_o and valid_o held stable. On an edge with ready_i=1: valid_o->0, ready_o->1, go to IDLE.
- ready_o=1 only in IDLE. valid_i is ignored outside IDLE.
- Latency: accept edge E0, valid_o=1 after edge E19.
- Minimum period is 21 cycles per message when ready_i is held at 1.
- RSC step, state (s1,s2,s3), input bit b:
  - a = b^s2^s3
  - z = a^s1^s3
  - next state = (a, s1, s2)
  - This is feedback 13 octal, feedforward 15 octal.
- ENC step i:
  - Encoder 1 uses b=u[i] and writes z1[i].
  - Encoder 2 uses b=u[pi(i)] and writes z2[i].
- TAIL step t (encoder 1 only): b = s2^s3, so a=0.
  - xt[t] = s2^s3
  - zt[t] = s1^s3
  - State shifts in a 0; it is all zero after t=2.
  - Encoder 2 state is held, not used.
- data_o layout:
  - [15:0] = u
  - [31:16] = z1
  - [47:32] = z2
  - [50:48] = xt[2:0]
  - [53:51] = zt[2:0]
- data_o changes only on entering OUT. Intermediate bits accumulate in internal registers.
- Simultaneous events:
  - valid_i=1 while in OUT is not accepted.
  - ready_i=1 outside OUT has no effect.
  - An OUT->IDLE edge never accepts a message in the same edge; acceptance needs ready_o=1 during the cycle.

Test Plan:
- Reset with valid_i=0: ready_o=1, valid_o=0, data_o=0. Assert reset mid-ENC: same values next cycle, and valid_o never rises for the aborted message.
- data_i=0x0000, ready_i=1: after 19 cycles valid_o=1 and data_o=54'h0 for one cycle, then ready_o=1.
- data_i=0x0001: data_o=54'h13_9E00_A74F_0001. This gives z1=0xA74F, z2=0x9E00, xt=3'b011, zt=3'b010.
- Backpressure: ready_i=0 for 10 cycles after valid_o. data_o/valid_o stay stable, ready_o=0, and a pulsed valid_i is ignored. Release ready_i and the message completes normally.
- Back-to-back: 0x0001 then 0x0000, valid_i held high and ready_i=1. Second acceptance occurs exactly 21 cycles after the first, and the outputs match the first two scenarios.
- Random 200 messages against a reference model with random ready_i stalls. Check that encoder 1's state is 000 after tail in every codeword.
